ofdm_rx_ctrl: RTL
=================

# ofdm_rx_ctrl

Receive-side sequencer that runs one OFDM demodulation pass: start `fft1024`, wait for it to finish, hand BSRAM `fft0` to the `ofdm` decoder, start it, and capture the 96-bit result. It also owns the single port of BSRAM `fft0` and shares it between three requesters: the sample loader, `fft1024` and `ofdm`. Only one requester drives the port at any time, with a guard cycle between owners. It sits between the top-level receive FSM and the `fft1024` / `ofdm` / `Gowin_SP_fft0` instances.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 65536: watchdog limit per engine run, in clk cycles.
- `AD_W`, 11: BSRAM `fft0` address width.
- `DATA_W`, 32: BSRAM `fft0` data width.

Ports:
- `clk` in 1: system clock, 27 MHz.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one pass; accepted only in IDLE.
- `busy` out 1: high from the cycle after acceptance until DONE.
- `done` out 1: one-cycle pulse at the end of a pass.
- `success` out 1: valid with `done`; it is held until the next acceptance.
- `err_timeout` out 1: valid with `done`; high if the watchdog fired.
- `res` out 96: latched decoder result; it is held until the next successful pass.
- `fft_start`, `fft_clear` out 1: controls to `fft1024`. `fft_finish` in 1.
- `dem_start`, `dem_clear` out 1: controls to `ofdm`. `dem_finish`, `dem_success` in 1; `dem_res` in 96.
- Requester ports for `ld_*`, `fft_*` and `dem_*`:
  - `*_oce`, `*_ce` in 1.
  - `*_ad` in AD_W.
  - `ld_wre`, `fft_wre` in 1.
  - `ld_din`, `fft_din` in DATA_W.
- `ram_oce`, `ram_ce`, `ram_wre` out 1; `ram_ad` out AD_W; `ram_din` out DATA_W: to `Gowin_SP_fft0`.
- `owner` out 2: current port owner, for debug.

## Operation
- States: IDLE, FFT_START, FFT_RUN, HANDOVER, DEM_START, DEM_RUN, ABORT, DONE.
- Owner encoding: LOAD=0, FFT=1, DEM=2, NONE=3.
  - The owner is a register, updated on the state transition.
  - IDLE → LOAD; FFT_* → FFT; HANDOVER → NONE; DEM_* → DEM; ABORT and DONE → NONE.
- Port mux:
  - Selects the owner's signals.
  - When owner is NONE, `ram_ce`, `ram_oce` and `ram_wre` are 0 and `ram_ad`/`ram_din` are 0.
  - When owner is DEM, `ram_wre` is 0 and `ram_din` is 0 (read-only).
  - Non-owners are ignored.
- Transitions:
  - IDLE & `start` → FFT_START. FFT_START → FFT_RUN.
  - FFT_RUN & `fft_finish` → HANDOVER. HANDOVER → DEM_START → DEM_RUN.
  - DEM_RUN & `dem_finish` → DONE. DONE → IDLE.
- Results: on `dem_finish`, register `dem_success` into `success`; if it is 1, also register `dem_res` into `res`.
- Watchdog:
  - The counter clears on entry to each RUN state and increments each cycle in RUN.
  - Reaching TIMEOUT_CYCLES−1 without a finish → ABORT.
  - ABORT pulses `fft_clear` or `dem_clear` (whichever engine was running) for one cycle, then goes to DONE with `success`=0 and `err_timeout`=1.
- Simultaneous events: a finish in the same cycle as the timeout wins, i.e. it is a normal completion.
- `start` while not in IDLE is ignored and not queued.
- Finishes outside the matching RUN state are ignored.

## Timing
- Reset values: state IDLE, owner LOAD.
  - Outputs `busy`, `done`, `success`, `err_timeout`, `fft_start`, `fft_clear`, `dem_start`, `dem_clear` = 0; `res` = 0.
  - Mux outputs follow LOAD.
- `start` sampled high at cycle T:
  - `busy`=1 and owner=FFT from T+1.
  - `fft_start`=1 during T+1 only.
- `fft_finish` at cycle F:
  - Owner NONE during F+1 (guard cycle).
  - Owner DEM and `dem_start`=1 during F+2.
- `dem_finish` at cycle D:
  - `done`=1 during D+1, with `success`, `res` and `err_timeout` updated in the same cycle; owner NONE.
  - D+2: IDLE, owner LOAD, `busy`=0.
- Timeout: ABORT lasts 1 cycle, `done` follows on the next cycle.
- `rst` mid-pass: next cycle is IDLE/LOAD with all pulses low. `fft_clear`/`dem_clear` are not pulsed, because the engines share `rst`.
- Mux path is combinational from requester inputs; the select is registered.

## Structure
- Package `ofdm_rx_pkg`:
  - Owner encoding constants.
  - State encoding.
  - `RES_W`=96.
  - Default `AD_W`/`DATA_W`.
- Sub-module `bsram_port_mux`: 3-way owner-selected mux with NONE gating and DEM write masking.
- The FSM and watchdog stay in `ofdm_rx_ctrl`.

## Test plan
- Normal pass: stubs finish after 40 (fft) and 25 (dem) cycles, dem_success=1, dem_res=96'h0C0B0A090807060504030201 → `done` 1 pulse, `success`=1, `res` equals the input; `fft_start`/`dem_start` are one cycle each, at T+1 and F+2.
- Ownership: all requesters drive ce=1 and distinct addresses 0x011/0x222/0x433 → `ram_ad` tracks LOAD→FFT→0(NONE)→DEM→0→LOAD at the specified cycles; `ram_wre` is never 1 while owner is DEM.
- Decoder failure: dem_success=0 with dem_res=all-ones → `success`=0, `res` keeps its previous value, `err_timeout`=0.
- Timeout: TIMEOUT_CYCLES=16, fft never finishes → `fft_clear` pulses at cycle T+17, `done` with `err_timeout`=1 and `success`=0; with the finish arriving exactly on cycle 15, it completes normally.
- Busy start: `start` held high through a whole pass → exactly one pass per IDLE visit, second acceptance at D+2.
- Reset mid-pass: `rst` asserted during DEM_RUN → next cycle owner=LOAD, `busy`=0, no `done`; a fresh `start` afterwards completes normally.

Source files
------------

// File: rtl/ofdm_rx_ctrl_pkg.sv
// Shared types and constants for the OFDM receive sequencer: BSRAM owner and FSM
// state encodings, result width and default BSRAM geometry.
package ofdm_rx_pkg;

    localparam int RES_W      = 96;
    localparam int DEF_AD_W   = 11;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_LOAD = 2'd0,
        OWN_FFT  = 2'd1,
        OWN_DEM  = 2'd2,
        OWN_NONE = 2'd3
    } owner_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FFT_START = 3'd1,
        ST_FFT_RUN   = 3'd2,
        ST_HANDOVER  = 3'd3,
        ST_DEM_START = 3'd4,
        ST_DEM_RUN   = 3'd5,
        ST_ABORT     = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    // Which requester may drive BSRAM fft0 while the sequencer sits in a given state.
    function automatic owner_e owner_of(input state_e st);
        case (st)
            ST_IDLE:                    return OWN_LOAD;
            ST_FFT_START, ST_FFT_RUN:   return OWN_FFT;
            ST_DEM_START, ST_DEM_RUN:   return OWN_DEM;
            default:                    return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ofdm_rx_ctrl_if.sv
// Single-port BSRAM access bundle; requesters drive it as master, the port mux
// consumes requesters as slave and drives the RAM side as master.
interface ofdm_rx_ctrl_if
    import ofdm_rx_pkg::*;
#(
    parameter int AD_W   = DEF_AD_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              oce;
    logic              ce;
    logic              wre;
    logic [AD_W-1:0]   ad;
    logic [DATA_W-1:0] din;

    modport master (output oce, ce, wre, ad, din);
    modport slave  (input  oce, ce, wre, ad, din);

endinterface

// File: rtl/ofdm_rx_ctrl_bsram_port_mux.sv
// Owner-selected 3-way mux onto the single BSRAM fft0 port. NONE parks the port
// fully idle; the decoder is read-only, so its write enable and data are masked.
module bsram_port_mux
    import ofdm_rx_pkg::*;
#(
    parameter int AD_W   = DEF_AD_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  owner_e         owner_i,
    ofdm_rx_ctrl_if.slave  ld_bus,
    ofdm_rx_ctrl_if.slave  fft_bus,
    ofdm_rx_ctrl_if.slave  dem_bus,
    ofdm_rx_ctrl_if.master ram_bus
);

    logic              sel_oce;
    logic              sel_ce;
    logic              sel_wre;
    logic [AD_W-1:0]   sel_ad;
    logic [DATA_W-1:0] sel_din;
    logic              wr_allowed;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path infers a latch.
        sel_oce = 1'b0;
        sel_ce  = 1'b0;
        sel_wre = 1'b0;
        sel_ad  = '0;
        sel_din = '0;
        case (owner_i)
            OWN_LOAD: begin
                sel_oce = ld_bus.oce;
                sel_ce  = ld_bus.ce;
                sel_wre = ld_bus.wre;
                sel_ad  = ld_bus.ad;
                sel_din = ld_bus.din;
            end
            OWN_FFT: begin
                sel_oce = fft_bus.oce;
                sel_ce  = fft_bus.ce;
                sel_wre = fft_bus.wre;
                sel_ad  = fft_bus.ad;
                sel_din = fft_bus.din;
            end
            OWN_DEM: begin
                sel_oce = dem_bus.oce;
                sel_ce  = dem_bus.ce;
                sel_wre = dem_bus.wre;
                sel_ad  = dem_bus.ad;
                sel_din = dem_bus.din;
            end
            default: ;
        endcase
    end

    assign wr_allowed  = (owner_i != OWN_DEM);

    assign ram_bus.oce = sel_oce;
    assign ram_bus.ce  = sel_ce;
    assign ram_bus.ad  = sel_ad;
    assign ram_bus.wre = sel_wre & wr_allowed;
    assign ram_bus.din = wr_allowed ? sel_din : '0;

endmodule

// File: rtl/ofdm_rx_ctrl.sv
// Receive-pass sequencer: FFT run, guarded BSRAM handover, decoder run, result
// capture, per-run watchdog, and ownership of the shared BSRAM fft0 port.
module ofdm_rx_ctrl
    import ofdm_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int AD_W           = DEF_AD_W,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             success,
    output logic             err_timeout,
    output logic [RES_W-1:0] res,
    output logic             fft_start,
    output logic             fft_clear,
    input  logic             fft_finish,
    output logic             dem_start,
    output logic             dem_clear,
    input  logic             dem_finish,
    input  logic             dem_success,
    input  logic [RES_W-1:0] dem_res,
    ofdm_rx_ctrl_if.slave    ld_bus,
    ofdm_rx_ctrl_if.slave    fft_bus,
    ofdm_rx_ctrl_if.slave    dem_bus,
    ofdm_rx_ctrl_if.master   ram_bus,
    output logic [1:0]       owner
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // cnt_q counts RUN cycles already elapsed, so this value marks the cycle in which
    // the count reaches TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    state_e           state_q, state_d;
    owner_e           owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, success_q, err_timeout_q;
    logic             fft_start_q, fft_clear_q, dem_start_q, dem_clear_q;
    logic [RES_W-1:0] res_q;
    logic             in_run;
    logic             wd_expired;

    assign in_run     = (state_q == ST_FFT_RUN) || (state_q == ST_DEM_RUN);
    assign wd_expired = (cnt_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_FFT_START;
            ST_FFT_START: state_d = ST_FFT_RUN;
            ST_FFT_RUN: begin
                if (fft_finish)      state_d = ST_HANDOVER;
                else if (wd_expired) state_d = ST_ABORT;
            end
            ST_HANDOVER:  state_d = ST_DEM_START;
            ST_DEM_START: state_d = ST_DEM_RUN;
            ST_DEM_RUN: begin
                if (dem_finish)      state_d = ST_DONE;
                else if (wd_expired) state_d = ST_ABORT;
            end
            ST_ABORT:     state_d = ST_DONE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_LOAD;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            success_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            fft_start_q   <= 1'b0;
            fft_clear_q   <= 1'b0;
            dem_start_q   <= 1'b0;
            dem_clear_q   <= 1'b0;
            res_q         <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_of(state_d);
            cnt_q       <= in_run ? cnt_q + CNT_W'(1) : '0;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            fft_start_q <= (state_d == ST_FFT_START);
            dem_start_q <= (state_d == ST_DEM_START);
            fft_clear_q <= (state_d == ST_ABORT) && (state_q == ST_FFT_RUN);
            dem_clear_q <= (state_d == ST_ABORT) && (state_q == ST_DEM_RUN);

            if (state_q == ST_IDLE && start) begin
                success_q     <= 1'b0;
                err_timeout_q <= 1'b0;
            end
            if (state_q == ST_DEM_RUN && dem_finish) begin
                success_q <= dem_success;
                if (dem_success) res_q <= dem_res;
            end
            if (state_q == ST_ABORT) begin
                success_q     <= 1'b0;
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign success     = success_q;
    assign err_timeout = err_timeout_q;
    assign res         = res_q;
    assign fft_start   = fft_start_q;
    assign fft_clear   = fft_clear_q;
    assign dem_start   = dem_start_q;
    assign dem_clear   = dem_clear_q;
    assign owner       = owner_q;

    bsram_port_mux #(
        .AD_W   (AD_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .owner_i (owner_q),
        .ld_bus  (ld_bus),
        .fft_bus (fft_bus),
        .dem_bus (dem_bus),
        .ram_bus (ram_bus)
    );

endmodule
